// File: rtl/wave_meter_pkg.sv
// Shared register map, control/status bit positions and detector state encoding
// for the wave_meter block.
package wave_meter_pkg;

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffStatus = 3'd1;
  localparam logic [2:0] OffPeriod = 3'd2;
  localparam logic [2:0] OffPeaks  = 3'd3;
  localparam logic [2:0] OffHyst   = 3'd4;

  localparam int CtrlEnBit  = 0;
  localparam int CtrlClrBit = 1;
  localparam int StatPvBit  = 0;
  localparam int StatOvfBit = 1;

  typedef enum logic [1:0] {
    StSeek    = 2'd0,
    StRising  = 2'd1,
    StFalling = 2'd2
  } det_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wave_meter_if.sv
// Single-cycle valid/ready register bus used to reach the wave_meter CSRs.
interface wave_meter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/wave_meter_detect.sv
// Peak/trough detector with hysteresis; reports extreme events and the clock distance
// between successive maxima to the CSR block.
module wave_meter_detect
  import wave_meter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [7:0]  hyst_i,
  input  logic [7:0]  in_i,
  output logic        max_evt_o,
  output logic [7:0]  max_val_o,
  output logic        min_evt_o,
  output logic [7:0]  min_val_o,
  output logic        period_evt_o,
  output logic [31:0] period_val_o,
  output logic        ovf_set_o
);

  det_state_e  state_q, state_d;
  logic [7:0]  samp_q, samp_d, prev_q, prev_d;
  logic [7:0]  cur_max_q, cur_max_d, cur_min_q, cur_min_d;
  logic [31:0] cnt_q, cnt_d;
  logic        have_q, have_d;
  logic        rise_done, fall_done;

  // 9-bit sums so samp + hyst cannot wrap around
  assign rise_done = ({1'b0, samp_q} + {1'b0, hyst_i}) < {1'b0, cur_max_q};
  assign fall_done = {1'b0, samp_q} > ({1'b0, cur_min_q} + {1'b0, hyst_i});

  assign max_val_o    = cur_max_q;
  assign min_val_o    = cur_min_q;
  assign period_val_o = sat_inc(cnt_q);

  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    prev_d       = prev_q;
    cur_max_d    = cur_max_q;
    cur_min_d    = cur_min_q;
    cnt_d        = cnt_q;
    have_d       = have_q;
    max_evt_o    = 1'b0;
    min_evt_o    = 1'b0;
    period_evt_o = 1'b0;
    ovf_set_o    = 1'b0;
    if (en_i) begin
      samp_d = in_i;
      prev_d = samp_q;
      cnt_d  = sat_inc(cnt_q);
      case (state_q)
        StSeek: begin
          if (samp_q > prev_q) begin
            state_d   = StRising;
            cur_max_d = samp_q;
          end else if (samp_q < prev_q) begin
            state_d   = StFalling;
            cur_min_d = samp_q;
          end
        end
        StRising: begin
          if (rise_done) begin
            max_evt_o    = 1'b1;
            period_evt_o = have_q;
            have_d       = 1'b1;
            cnt_d        = '0;
            cur_min_d    = samp_q;
            state_d      = StFalling;
          end else if (samp_q > cur_max_q) begin
            cur_max_d = samp_q;
          end
        end
        StFalling: begin
          if (fall_done) begin
            min_evt_o = 1'b1;
            cur_max_d = samp_q;
            state_d   = StRising;
          end else if (samp_q < cur_min_q) begin
            cur_min_d = samp_q;
          end
        end
        default: state_d = StSeek;
      endcase
      ovf_set_o = (cnt_d == 32'hFFFF_FFFF);
    end else begin
      state_d = StSeek;
      cnt_d   = '0;
      have_d  = 1'b0;
    end
    // Clear wins over any event detected in the same cycle
    if (clr_i) begin
      state_d      = StSeek;
      cnt_d        = '0;
      have_d       = 1'b0;
      max_evt_o    = 1'b0;
      min_evt_o    = 1'b0;
      period_evt_o = 1'b0;
      ovf_set_o    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StSeek;
      samp_q    <= '0;
      prev_q    <= '0;
      cur_max_q <= '0;
      cur_min_q <= '0;
      cnt_q     <= '0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      prev_q    <= prev_d;
      cur_max_q <= cur_max_d;
      cur_min_q <= cur_min_d;
      cnt_q     <= cnt_d;
      have_q    <= have_d;
    end
  end

endmodule

// File: rtl/wave_meter.sv
// Waveform period/peak meter: CSR bus slave plus the wave_meter_detect detector.
// Define WAVE_METER_HYST_EN to make the hysteresis register writable.
module wave_meter
  import wave_meter_pkg::*;
(
  input logic         clk,
  input logic         resetn,
  wave_meter_if.slave bus,
  input logic [7:0]   in
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic [31:0] period_q, period_d;
  logic [7:0]  max_q, max_d, min_q, min_d;
  logic        pv_q, pv_d, ovf_q, ovf_d;
  logic [7:0]  hyst;
  logic [2:0]  off;
  logic        accept, wr, wr_byte0, clr;
  logic        max_evt, min_evt, period_evt, ovf_set;
  logic [7:0]  max_val, min_val;
  logic [31:0] period_val;
  logic        unused_bits;

  assign accept   = bus.valid & ~ready_q;
  assign wr       = accept & (|bus.wstrb);
  assign wr_byte0 = wr & bus.wstrb[0];
  assign off      = bus.addr[4:2];
  assign clr      = wr_byte0 & (off == OffCtrl) & bus.wdata[CtrlClrBit];

  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata[31:2], bus.wstrb[3:1]};

`ifdef WAVE_METER_HYST_EN
  logic [7:0] hyst_q, hyst_d;

  always_comb begin
    hyst_d = hyst_q;
    if (wr_byte0 && off == OffHyst) hyst_d = bus.wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hyst_q <= '0;
    else         hyst_q <= hyst_d;
  end

  assign hyst = hyst_q;
`else
  assign hyst = 8'h00;
`endif

  always_comb begin
    ready_d = accept;
    rdata_d = 32'h0;
    if (accept && bus.wstrb == 4'h0) begin
      case (off)
        OffCtrl:   rdata_d[CtrlEnBit] = en_q;
        OffStatus: begin
          rdata_d[StatPvBit]  = pv_q;
          rdata_d[StatOvfBit] = ovf_q;
        end
        OffPeriod: rdata_d = period_q;
        OffPeaks:  rdata_d = {16'h0, min_q, max_q};
        OffHyst:   rdata_d = {24'h0, hyst};
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    en_d     = en_q;
    period_d = period_q;
    max_d    = max_q;
    min_d    = min_q;
    pv_d     = pv_q;
    ovf_d    = ovf_q;
    if (wr_byte0 && off == OffCtrl) en_d = bus.wdata[CtrlEnBit];
    if (clr) begin
      period_d = '0;
      max_d    = '0;
      min_d    = '0;
      pv_d     = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (max_evt) max_d = max_val;
      if (min_evt) min_d = min_val;
      if (period_evt) begin
        period_d = period_val;
        pv_d     = 1'b1;
      end
      if (ovf_set) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      period_q <= '0;
      max_q    <= '0;
      min_q    <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      period_q <= period_d;
      max_q    <= max_d;
      min_q    <= min_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  wave_meter_detect u_detect (
    .clk          (clk),
    .resetn       (resetn),
    .en_i         (en_q),
    .clr_i        (clr),
    .hyst_i       (hyst),
    .in_i         (in),
    .max_evt_o    (max_evt),
    .max_val_o    (max_val),
    .min_evt_o    (min_evt),
    .min_val_o    (min_val),
    .period_evt_o (period_evt),
    .period_val_o (period_val),
    .ovf_set_o    (ovf_set)
  );

endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: bus reads are predicted by a sample-level reference
// model of the meter and checked by an independent monitor when ready pulses.
module tb_wave_meter;
  import wave_meter_pkg::*;

  localparam int GenHold = 0, GenRamp = 1, GenTri = 2, GenRand = 3;
  localparam longint CntMax = 64'hFFFF_FFFF;

  typedef struct {
    bit          rd;
    int          off;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_s;

  wave_meter_if bus_if ();

  wave_meter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if),
    .in     (in_s)
  );

  always #5 clk = ~clk;

  int   n_pass = 0, n_checks = 0, rdy_pulses = 0;
  exp_t exp_q[$];

  // Reference model: a sample stream tracker, integers only
  int     m_en, m_hyst, m_samp, m_prev, m_dir, m_cmax, m_cmin, m_max, m_min;
  int     m_pv, m_ovf, m_have;
  longint m_cnt, m_period;
  bit     m_rdy;
  int     g_mode, g_val, g_up;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_en = 0; m_hyst = 0; m_samp = 0; m_prev = 0; m_dir = 0; m_cmax = 0; m_cmin = 0;
    m_max = 0; m_min = 0; m_pv = 0; m_ovf = 0; m_have = 0; m_cnt = 0; m_period = 0;
    m_rdy = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input int off);
    logic [31:0] v = 32'h0;
    case (off)
      0: v[0] = m_en[0];
      1: begin v[0] = m_pv[0]; v[1] = m_ovf[0]; end
      2: v = m_period[31:0];
      3: v = {16'h0, m_min[7:0], m_max[7:0]};
      4: v = {24'h0, m_hyst[7:0]};
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic bit model_peak_next();
    return (m_en != 0) && (m_dir > 0) && (m_samp + m_hyst < m_cmax);
  endfunction

  // Advance the model over one rising edge using the inputs presented before it
  task automatic model_edge();
    bit acc, wr, clr, peak;
    int off;
    exp_t e;
    if (resetn !== 1'b1) return;
    acc = (bus_if.valid === 1'b1) && !m_rdy;
    wr  = acc && (bus_if.wstrb != 4'h0);
    off = int'(bus_if.addr[4:2]);
    if (acc) begin
      e.rd = !wr; e.off = off; e.val = model_read(off);
      exp_q.push_back(e);
    end
    clr   = wr && off == 0 && bus_if.wstrb[0] && bus_if.wdata[1];
    m_rdy = acc;
    peak  = 1'b0;
    if (m_en != 0) begin
      if (m_dir == 0) begin
        if (m_samp > m_prev) begin m_dir = 1; m_cmax = m_samp; end
        else if (m_samp < m_prev) begin m_dir = -1; m_cmin = m_samp; end
      end else if (m_dir > 0) begin
        if (m_samp + m_hyst < m_cmax) begin
          peak = 1'b1;
          if (m_have != 0) begin
            m_period = (m_cnt + 1 > CntMax) ? CntMax : m_cnt + 1;
            m_pv = 1;
          end
          m_have = 1; m_cnt = 0; m_max = m_cmax; m_cmin = m_samp; m_dir = -1;
        end else if (m_samp > m_cmax) m_cmax = m_samp;
      end else begin
        if (m_samp > m_cmin + m_hyst) begin
          m_min = m_cmin; m_cmax = m_samp; m_dir = 1;
        end else if (m_samp < m_cmin) m_cmin = m_samp;
      end
      if (!peak) begin
        if (m_cnt < CntMax) m_cnt++;
        if (m_cnt == CntMax) m_ovf = 1;
      end
      m_prev = m_samp;
      m_samp = int'(in_s);
    end else begin
      m_dir = 0; m_cnt = 0; m_have = 0;
    end
    if (clr) begin
      m_period = 0; m_max = 0; m_min = 0; m_pv = 0; m_ovf = 0;
      m_cnt = 0; m_have = 0; m_dir = 0;
    end
    if (wr && off == 0 && bus_if.wstrb[0]) m_en = int'(bus_if.wdata[0]);
`ifdef WAVE_METER_HYST_EN
    if (wr && off == 4 && bus_if.wstrb[0]) m_hyst = int'(bus_if.wdata[7:0]);
`endif
  endtask

  task automatic next_sample();
    int v;
    case (g_mode)
      GenRamp: begin
        in_s = 8'(g_val);
        if (g_up != 0) begin
          if (g_val == 255) begin g_up = 0; g_val--; end else g_val++;
        end else begin
          if (g_val == 0) begin g_up = 1; g_val++; end else g_val--;
        end
      end
      GenTri: begin
        v = g_val;
        // occasional glitch against the direction of travel
        if ($urandom_range(0, 7) == 0) v = (g_up != 0) ? v - 3 : v + 3;
        if (v < 8'h40) v = 8'h40;
        if (v > 8'hC0) v = 8'hC0;
        in_s = 8'(v);
        if (g_up != 0) begin
          if (g_val >= 8'hC0) begin g_up = 0; g_val -= 2; end else g_val += 2;
        end else begin
          if (g_val <= 8'h40) begin g_up = 1; g_val += 2; end else g_val -= 2;
        end
      end
      GenRand: in_s = 8'($urandom_range(0, 255));
      default: ;
    endcase
  endtask

  task automatic tick();
    next_sample();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_op(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] a;
    while (m_rdy) tick();
    a = $urandom();
    a[4:2] = off;
    bus_if.valid = 1'b1; bus_if.addr = a; bus_if.wstrb = strb; bus_if.wdata = data;
    tick();
    bus_if.valid = 1'b0; bus_if.wstrb = 4'h0;
  endtask

  task automatic read_results();
    bus_op(OffPeriod, 4'h0, 32'h0);
    bus_op(OffPeaks, 4'h0, 32'h0);
    bus_op(OffStatus, 4'h0, 32'h0);
  endtask

  task automatic check_seek(input string name);
    check(name, 32'(dut.u_detect.state_q), 32'(StSeek));
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        prev_rdy = 1'b0;
        continue;
      end
      if (bus_if.ready === 1'b1 || m_rdy) check("ready", 32'(bus_if.ready), 32'(m_rdy));
      if (bus_if.ready === 1'b1) begin
        rdy_pulses++;
        if (prev_rdy) check("ready_back_to_back", 32'(prev_rdy), 32'd0);
        if (exp_q.size() == 0) begin
          check("ready_without_request", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          if (e.rd) check($sformatf("rdata_off%0d", e.off), bus_if.rdata, e.val);
        end
      end
      prev_rdy = (bus_if.ready === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int waited;
    int p0;
    bus_if.valid = 1'b0; bus_if.wstrb = 4'h0; bus_if.addr = '0; bus_if.wdata = '0;
    in_s = 8'h00; resetn = 1'b1; g_mode = GenHold; g_val = 0; g_up = 1;
    model_reset();
    #1 resetn = 1'b0;
    #1;
    check("reset_ready", 32'(bus_if.ready), 32'd0);
    check("reset_rdata", bus_if.rdata, 32'd0);
    repeat (2) tick();
    #2 resetn = 1'b1;
    check_seek("reset_state");
    for (int o = 0; o < 8; o++) bus_op(3'(o), 4'h0, 32'h0);

    // full-scale ramp 0x00..0xFF..0x00
    g_mode = GenRamp; g_val = 0; g_up = 1;
    bus_op(OffCtrl, 4'h1, 32'h1);
    repeat (1100) tick();
    read_results();

    // clear+enable written on the very edge that detects a maximum
    waited = 0;
    while (!model_peak_next() && waited < 2000) begin
      tick();
      waited++;
    end
    check("peak_wait", 32'(waited < 2000), 32'd1);
    bus_op(OffCtrl, 4'h1, 32'h3);
    check_seek("clear_on_event_state");
    read_results();

    // constant input gives no transitions
    g_mode = GenHold; in_s = 8'h80;
    repeat (5) tick();
    bus_op(OffCtrl, 4'h1, 32'h3);
    repeat (100) tick();
    check_seek("flat_state");
    read_results();

    // valid held high over three STATUS reads
    while (m_rdy) tick();
    p0 = rdy_pulses;
    bus_if.valid = 1'b1; bus_if.addr = 32'h4; bus_if.wstrb = 4'h0;
    repeat (6) tick();
    bus_if.valid = 1'b0;
    repeat (2) tick();
    check("ready_pulses", 32'(rdy_pulses - p0), 32'd3);

`ifdef WAVE_METER_HYST_EN
    bus_op(OffHyst, 4'h1, 32'h4);
    bus_op(OffHyst, 4'h0, 32'h0);
    g_mode = GenTri; g_val = 8'h40; g_up = 1;
    bus_op(OffCtrl, 4'h1, 32'h3);
    repeat (800) tick();
    read_results();
`else
    bus_op(OffHyst, 4'h1, 32'h4);
    bus_op(OffHyst, 4'h0, 32'h0);
`endif

    // randomized traffic against random samples
    g_mode = GenRand;
    bus_op(OffCtrl, 4'h1, 32'h1);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom();
      d[0] = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus_op(3'($urandom_range(0, 7)), s, d);
      repeat ($urandom_range(0, 4)) tick();
    end

    // asynchronous reset in the middle of a ramp and of a ready pulse
    g_mode = GenRamp; g_val = 0; g_up = 1;
    bus_op(OffCtrl, 4'h1, 32'h3);
    repeat (900) tick();
    bus_op(OffStatus, 4'h0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_ready", 32'(bus_if.ready), 32'd0);
    check("async_reset_rdata", bus_if.rdata, 32'd0);
    model_reset();
    exp_q.delete();
    repeat (3) tick();
    #2 resetn = 1'b1;
    check_seek("after_reset_state");
    read_results();
    bus_op(OffCtrl, 4'h1, 32'h1);
    repeat (1100) tick();
    read_results();

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port valid, input, 1, bus request from the initiator.
REQ-004 SHALL have port ready, output, 1, bus completion pulse.
REQ-005 SHALL have port wstrb, input, 4, byte write strobes; all zero means read.
REQ-006 SHALL have port addr, input, 32, byte address; only addr[4:2] decoded.
REQ-007 SHALL have port wdata, input, 32, write data.
REQ-008 SHALL have port rdata, output, 32, read data, valid while ready=1.
REQ-009 SHALL have port in, input, 8, unsigned waveform sample under measurement.

Function
REQ-010 SHALL decode the register map: 0 CTRL (bit0 enable, bit1 clear), 1 STATUS (bit0 period_valid, bit1 overflow), 2 PERIOD[31:0], 3 PEAKS ({16'h0, min[7:0], max[7:0]}), 4 HYST[7:0]; unmapped offsets read 0, writes ignored.
REQ-011 SHALL accept a transaction when valid=1 and ready=0, drive ready=1 for exactly one cycle on the next cycle, then drive ready=0.
REQ-012 SHALL apply writes byte-wise per wstrb on the accept cycle; STATUS, PERIOD and PEAKS are read-only.
REQ-013 SHALL treat CTRL.clear as self-clearing: it reads 0 and acts only in the cycle it is written as 1.
REQ-014 SHALL register in into samp every cycle while enabled and keep the previous sample in prev.
REQ-015 SHALL run detector states SEEK, RISING and FALLING.
REQ-016 SHALL in SEEK go to RISING with cur_max=samp when samp>prev, go to FALLING with cur_min=samp when samp<prev, and otherwise stay in SEEK.
REQ-017 SHALL in RISING set cur_max=samp when samp>cur_max.
REQ-018 SHALL in RISING, when samp+HYST<cur_max (9-bit compare), record a max event: max<=cur_max, cur_min<=samp, go to FALLING.
REQ-019 SHALL handle FALLING symmetrically: track cur_min; when samp>cur_min+HYST (9-bit), record a min event with min<=cur_min and cur_max<=samp, then go to RISING.
REQ-020 SHALL treat equal consecutive samples as no transition in every state.
REQ-021 SHALL run a 32-bit counter of clocks since the last max event, counting every enabled cycle and saturating at 32'hFFFF_FFFF with STATUS.overflow set (sticky).
REQ-022 SHALL on a max event, if a previous max event exists, load PERIOD<=counter+1 and set STATUS.period_valid (sticky); the counter then restarts at 0.
REQ-023 SHALL on enable=0 hold PERIOD, PEAKS and STATUS, force the state to SEEK, zero the counter and clear the have-previous-max flag.
REQ-024 SHALL on clear zero PERIOD, PEAKS, STATUS, the counter and have-previous-max, and force SEEK; clear overrides any detector event in the same cycle.

Reset
REQ-025 SHALL on resetn=0 set ready=0, rdata=0, CTRL=0, HYST=0, PERIOD=0, PEAKS=0, STATUS=0, samp=prev=0, counter=0 and state SEEK.
REQ-026 SHALL on reset asserted mid-transaction abandon the transaction without a ready pulse.

Configuration
REQ-027 SHALL, with WAVE_METER_HYST_EN defined, implement HYST as a writable register used by REQ-018/019.
REQ-028 SHALL, without WAVE_METER_HYST_EN, hardwire HYST to 0, read offset 4 as 0 and ignore writes to it.

Structure
REQ-029 SHALL place the register offsets, CTRL/STATUS bit positions and the detector state encoding in package wave_meter_pkg.
REQ-030 SHALL implement the detector (REQ-015..022) as sub-module wave_meter_detect; the top level holds the bus logic and the CSRs.

Verification
REQ-031 SHALL cover: enable=1, HYST=0, in ramps by 1 per clock 0x00->0xFF->0x00 repeatedly -> after the second max, PERIOD=510, PEAKS=0x0000_00FF... (max=0xFF, min=0x00), period_valid=1.
REQ-032 SHALL cover (HYST_EN): HYST=4, triangle 0x40..0xC0 with +/-3 noise glitches -> no extra events, max=0xC0, min=0x40.
REQ-033 SHALL cover: write CTRL=0x3 in the same cycle as a max event -> PERIOD=0, STATUS=0, state SEEK.
REQ-034 SHALL cover: constant in=0x80 for 100 clocks after enable -> state SEEK, period_valid=0, PEAKS=0.
REQ-035 SHALL cover: valid held high across 3 reads of STATUS -> one ready pulse per accept, never consecutive ready cycles.
REQ-036 SHALL cover: resetn pulled low mid-ramp, asynchronous to clk -> all outputs 0 immediately, and measurement restarts from SEEK after release.
